// File: rtl/nand2_rr_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nand2_sched_pkg : shared types and constants for the nand2 RR scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package nand2_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int OP_COUNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/nand2_rr_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nand2_rr_sched_if : requester/response bus of the nand2 RR scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
interface nand2_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  import nand2_sched_pkg::*;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_a;
  logic [NUM_REQ-1:0]    req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic                  rsp_c;
  logic                  busy;
  logic [IDX_W-1:0]      grant_idx;
  logic [OP_COUNT_W-1:0] op_count;
  // Preload of the completion counter, only honoured while no op completes
  logic                  cnt_load;
  logic [OP_COUNT_W-1:0] cnt_load_val;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, cnt_load, cnt_load_val,
    input  req_ready, rsp_valid, rsp_c, busy, grant_idx, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, cnt_load, cnt_load_val,
    output req_ready, rsp_valid, rsp_c, busy, grant_idx, op_count
  );
endinterface
`default_nettype wire

// File: rtl/nand2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nand2 : registered two-input NAND gate, active-high synchronous reset
// Rev 1.0
// ---------------------------------------------------------------------------
module nand2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic a,
  input  wire logic b,
  output logic      c
);
  logic c_q;

  always_ff @(posedge clk) begin
    if (rst) c_q <= 1'b0;
    else     c_q <= ~(a & b);
  end

  assign c = c_q;
endmodule
`default_nettype wire

// File: rtl/nand2_rr_sched_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick starting after last_i
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req_i,
  input  wire logic [IDX_W-1:0]   last_i,
  output logic      [NUM_REQ-1:0] gnt_o,
  output logic      [IDX_W-1:0]   idx_o
);
  logic [IDX_W:0] pos;
  logic           found;

  // One extra bit on pos covers last_i + NUM_REQ before the wrap subtraction
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = {1'b0, last_i} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        gnt_o = NUM_REQ'(1) << pos[IDX_W-1:0];
        idx_o = pos[IDX_W-1:0];
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/nand2_rr_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nand2_rr_sched : round-robin time-sharing of one registered nand2 gate
// Rev 1.0
// ---------------------------------------------------------------------------
module nand2_rr_sched
  import nand2_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  wire logic         clk,
  input  wire logic         rst,
  nand2_rr_sched_if.slave   bus
);
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, owner_q;
  logic                  op_a_q, op_b_q;
  logic [OP_COUNT_W-1:0] op_count_q;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  nand_c;
  logic                  accept, complete;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  // Operand registers stay put through RESP, so the gate output is stable
  nand2 u_nand2 (
    .clk (clk),
    .rst (~rst),
    .a   (op_a_q),
    .b   (op_b_q),
    .c   (nand_c)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    complete      = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_c     = 1'b0;
    bus.busy      = 1'b0;
    bus.grant_idx = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          bus.req_ready = arb_gnt;
          if (|bus.req_valid) begin
            accept  = 1'b1;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          bus.busy      = 1'b1;
          bus.grant_idx = owner_q;
          state_d       = RESP;
        end
        RESP: begin
          bus.busy      = 1'b1;
          bus.grant_idx = owner_q;
          bus.rsp_valid = NUM_REQ'(1) << owner_q;
          bus.rsp_c     = nand_c;
          if (bus.rsp_ready[owner_q]) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      op_a_q     <= 1'b0;
      op_b_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q  <= bus.req_a[arb_idx];
        op_b_q  <= bus.req_b[arb_idx];
        owner_q <= arb_idx;
        last_q  <= arb_idx;
      end
      if (complete)          op_count_q <= op_count_q + OP_COUNT_W'(1);
      else if (bus.cnt_load) op_count_q <= bus.cnt_load_val;
    end
  end

  assign bus.op_count = op_count_q;
endmodule
`default_nettype wire

// File: tb/tb_nand2_rr_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nand2_rr_sched : vector table plus scoreboard bench for nand2_rr_sched
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_nand2_rr_sched;
  import nand2_sched_pkg::*;

  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nand2_rr_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  nand2_rr_sched #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int   idx;
    logic c;
  } exp_t;

  typedef struct {
    int   idx;
    logic a;
    logic b;
    logic exp_c;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: model result pushed at accept, compared at response handshake
  always @(negedge clk) begin
    if (rst) begin
      check("onehot_req_ready", 32'($onehot0(bus.req_ready)), 32'd1);
      check("onehot_rsp_valid", 32'($onehot0(bus.rsp_valid)), 32'd1);
      check("ready_valid_overlap", 32'((|bus.req_ready) && (|bus.rsp_valid)), 32'd0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{idx: i, c: ~(bus.req_a[i] & bus.req_b[i])});
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_rsp", 32'(sb.size()), 32'd1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_owner", 32'(i), 32'(e.idx));
            check("sb_rsp_c", 32'(bus.rsp_c), 32'(e.c));
          end
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0;
  endtask

  task automatic run_op(input vec_t v);
    bit got;
    bus.req_valid = NUM_REQ'(1) << v.idx;
    bus.req_a     = {NUM_REQ{v.a}};
    bus.req_b     = {NUM_REQ{v.b}};
    #1;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (bus.req_ready[v.idx]) begin
        got = 1'b1;
        break;
      end
      tick();
      #1;
    end
    check("accept_timeout", 32'(got), 32'd1);
    if (!got) begin
      bus.req_valid = '0;
      return;
    end
    tick();
    bus.req_valid = '0;
    #1;
    check("issue_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("issue_busy", 32'(bus.busy), 32'd1);
    check("issue_grant_idx", 32'(bus.grant_idx), 32'(v.idx));
    tick();
    #1;
    check("rsp_valid_at_T+2", 32'(bus.rsp_valid), 32'(1 << v.idx));
    check("rsp_c_table", 32'(bus.rsp_c), 32'(v.exp_c));
    bus.rsp_ready = NUM_REQ'(1) << v.idx;
    tick();
    bus.rsp_ready = '0;
    exp_cnt++;
    #1;
    check("op_count", 32'(bus.op_count), exp_cnt & 32'hFFFF);
    check("idle_not_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order[6];
    int exp_order[6];
    int n_g;
    int gi;
    bit got;

    vecs[0] = '{2, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{2, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{3, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{3, 1'b1, 1'b1, 1'b0};
    exp_order = '{0, 1, 2, 3, 0, 1};

    bus.req_valid    = '1;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.rsp_ready    = '0;
    bus.cnt_load     = 1'b0;
    bus.cnt_load_val = '0;
    rst              = 1'b0;

    // Reset held with every requester valid
    repeat (2) begin
      tick();
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_c", 32'(bus.rsp_c), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
      check("rst_op_count", 32'(bus.op_count), 32'd0);
    end
    tick();
    rst = 1'b1;
    #1;
    check("first_ready_req0", 32'(bus.req_ready), 32'b0001);

    // Reset dropped during RESP abandons the op
    tick();
    bus.req_valid = '0;
    #1;
    check("midrst_issue_busy", 32'(bus.busy), 32'd1);
    tick();
    #1;
    check("midrst_resp_valid", 32'(bus.rsp_valid), 32'b0001);
    check("midrst_resp_c", 32'(bus.rsp_c), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("midrst_idle", 32'(bus.busy), 32'd0);
    check("midrst_op_count", 32'(bus.op_count), 32'd0);
    sb.delete();

    // Reset in the same cycle as a would-be accept latches nothing
    bus.req_valid = 4'b0010;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check("rst_accept_busy", 32'(bus.busy), 32'd0);
    bus.req_valid = '1;
    #1;
    check("rst_accept_ptr", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    tick();

    foreach (vecs[k]) run_op(vecs[k]);

    // Fairness with every requester valid and responses always accepted
    do_reset(2);
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    bus.req_a     = 4'b1010;
    bus.req_b     = 4'b1100;
    n_g = 0;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (|bus.req_ready) begin
        gi = -1;
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gi = i;
        if (n_g < 6) order[n_g] = gi;
        n_g++;
      end
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    exp_cnt = 6;
    #1;
    check("fair_op_count", 32'(bus.op_count), 32'd6);
    check("fair_grants", 32'(n_g), 32'd6);
    for (int k = 0; k < 6; k++) check("fair_order", 32'(order[k]), 32'(exp_order[k]));

    // Backpressure on requester 1, others waiting, non-owner rsp_ready high
    tick();
    bus.req_valid = 4'b0010;
    bus.req_a     = 4'b0010;
    bus.req_b     = 4'b0000;
    #1;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (bus.req_ready[1]) begin
        got = 1'b1;
        break;
      end
      tick();
      #1;
    end
    check("bp_accept", 32'(got), 32'd1);
    tick();
    bus.req_valid = 4'b1101;
    bus.rsp_ready = 4'b1101;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
      check("bp_rsp_c", 32'(bus.rsp_c), 32'd1);
      check("bp_no_ready", 32'(bus.req_ready), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
      check("bp_grant_idx", 32'(bus.grant_idx), 32'd1);
      tick();
    end
    bus.rsp_ready = 4'b0010;
    tick();
    bus.rsp_ready = '0;
    exp_cnt++;
    #1;
    check("bp_next_grant", 32'(bus.req_ready), 32'b0100);
    check("bp_op_count", 32'(bus.op_count), exp_cnt & 32'hFFFF);
    bus.req_valid = '0;

    // Counter wrap via preload
    tick();
    bus.cnt_load     = 1'b1;
    bus.cnt_load_val = 16'hFFFF;
    tick();
    bus.cnt_load = 1'b0;
    #1;
    check("wrap_preload", 32'(bus.op_count), 32'hFFFF);
    exp_cnt = 32'hFFFF;
    run_op('{0, 1'b0, 1'b0, 1'b1});
    check("wrap_zero", 32'(bus.op_count), 32'd0);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
